// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, defaults and queue entry type for the fetch stage
package fetch_pkg;

    localparam int                    FETCH_XLEN     = 32;
    localparam logic [31:0]           FETCH_NOP      = 32'h0000_0013;
    localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = '0;

    typedef struct packed {
        logic [31:0]           instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [FETCH_XLEN-1:0] word_align(input logic [FETCH_XLEN-1:0] addr);
        return {addr[FETCH_XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - small synchronous FIFO of fetched instruction/pc pairs
module instr_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  fetch_entry_t               data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(QDEPTH):0]    count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output fetch_entry_t               head_o
);

    localparam int PW = $clog2(QDEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    fetch_entry_t  mem_q [QDEPTH];
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return PW'((32'(p) + 32'd1) % 32'(QDEPTH));
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(QDEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full queue may still accept a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_next(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_next(rd_ptr_q);
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, IROM read issue and instruction queue feeding control
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN      = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = FETCH_RESET_PC,
    parameter int              QDEPTH    = 2,
    parameter logic [31:0]     NOP_INSTR = FETCH_NOP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            setup,
    input  logic            load_first_addr,
    input  logic [XLEN-1:0] first_addr,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            stall,
    output logic            irom_read_en,
    output logic [XLEN-1:0] irom_addr,
    input  logic [31:0]     irom_rdata,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    output logic            misalign_err
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            epoch_q, epoch_d;
    logic            inflight_q, inflight_d;
    logic            inflight_epoch_q, inflight_epoch_d;
    logic            misalign_q, misalign_d;

    logic [CW-1:0]   q_count;
    logic            q_full, q_empty;
    fetch_entry_t    q_head, push_entry;

    logic            flush, do_load, do_branch;
    logic            live_resp, push, pop, issue;
    logic [CW:0]     occupancy;

    assign do_load   = !setup && load_first_addr;
    assign do_branch = !setup && !load_first_addr && br_taken;
    assign flush     = setup || load_first_addr || br_taken;

    // Responses issued under an older epoch belong to a path that was redirected away.
    assign live_resp = inflight_q && (inflight_epoch_q == epoch_q);
    assign push      = live_resp && !flush;

    assign instr_valid = !q_empty && !setup;
    assign pop         = instr_valid && !stall;

    // Count the response landing this cycle so a stalled queue can never overflow.
    assign occupancy = (CW+1)'(q_count) + (CW+1)'(live_resp) - (CW+1)'(pop);
    assign issue     = rst_n && !flush && !(q_full && !pop)
                       && (occupancy < (CW+1)'(QDEPTH));

    always_comb begin
        pc_d             = pc_q;
        epoch_d          = epoch_q;
        misalign_d       = 1'b0;
        inflight_d       = issue;
        inflight_epoch_d = epoch_q;
        inflight_pc_d    = pc_q;
        if (do_load) begin
            pc_d       = {first_addr[XLEN-1:2], 2'b00};
            misalign_d = (first_addr[1:0] != 2'b00);
        end else if (do_branch) begin
            pc_d       = {br_target[XLEN-1:2], 2'b00};
            misalign_d = (br_target[1:0] != 2'b00);
        end else if (issue) begin
            pc_d = pc_q + XLEN'(4);
        end
        if (flush) epoch_d = !epoch_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q             <= RESET_PC;
            epoch_q          <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_epoch_q <= 1'b0;
            inflight_pc_q    <= RESET_PC;
            misalign_q       <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            epoch_q          <= epoch_d;
            inflight_q       <= inflight_d;
            inflight_epoch_q <= inflight_epoch_d;
            inflight_pc_q    <= inflight_pc_d;
            misalign_q       <= misalign_d;
        end
    end

    assign push_entry = '{instr: irom_rdata, pc: inflight_pc_q};

    instr_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (flush),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty),
        .head_o  (q_head)
    );

    assign irom_read_en = issue;
    assign irom_addr    = pc_q;
    assign instr_out    = instr_valid ? q_head.instr : NOP_INSTR;
    assign instr_pc     = instr_valid ? q_head.pc : RESET_PC;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for the fetch stage with a 1-cycle IROM model
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        setup = 1'b1;
    logic        load_first_addr = 1'b0;
    logic [31:0] first_addr = '0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        stall = 1'b0;
    logic        irom_read_en;
    logic [31:0] irom_addr;
    logic [31:0] irom_rdata = '0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        misalign_err;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_consumed = 0;
    logic [31:0] exp_q[$];
    bit          sb_en = 1'b0;
    logic [31:0] sb_pc;

    instr_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .setup           (setup),
        .load_first_addr (load_first_addr),
        .first_addr      (first_addr),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .stall           (stall),
        .irom_read_en    (irom_read_en),
        .irom_addr       (irom_addr),
        .irom_rdata      (irom_rdata),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] irom_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h1E02_7413;
        return {a[15:0] ^ 16'hA55A, a[31:16] ^ a[15:0]};
    endfunction

    always @(posedge clk) begin
        if (irom_read_en) irom_rdata <= irom_word(irom_addr);
    end

    // Every consumed instruction must be the next expected PC with its IROM word.
    always @(negedge clk) begin
        if (sb_en && rst_n && instr_valid && !stall) begin
            n_checks++;
            n_consumed++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, want no instruction", instr_pc, instr_out);
            end else begin
                sb_pc = exp_q.pop_front();
                if (instr_pc !== sb_pc || instr_out !== irom_word(sb_pc)) begin
                    n_fail++;
                    $display("FAIL sb_stream: got pc=%h instr=%h, want pc=%h instr=%h",
                             instr_pc, instr_out, sb_pc, irom_word(sb_pc));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_restart(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_checks++; if (irom_read_en !== 1'b0) begin n_fail++; $display("FAIL reset_read_en: got %b want 0", irom_read_en); end
        n_checks++; if (irom_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 00000000", irom_addr); end
        n_checks++; if (instr_out !== 32'h13) begin n_fail++; $display("FAIL reset_instr: got %h want 00000013", instr_out); end
        n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 00000000", instr_pc); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        n_checks++; if (irom_read_en !== 1'b0) begin n_fail++; $display("FAIL setup_idle_read_en: got %b want 0", irom_read_en); end
    endtask

    task automatic test_load_stream();
        int base;
        cyc();
        setup = 1'b0; load_first_addr = 1'b1; first_addr = 32'h100; stall = 1'b0;
        sb_restart(32'h100, 64); sb_en = 1'b1; base = n_consumed;
        #1;
        n_checks++; if (irom_read_en !== 1'b0) begin n_fail++; $display("FAIL load_cycle_read_en: got %b want 0", irom_read_en); end
        cyc(); load_first_addr = 1'b0; #1;
        n_checks++; if (irom_read_en !== 1'b1 || irom_addr !== 32'h100) begin n_fail++; $display("FAIL load_issue0: got en=%b addr=%h want en=1 addr=00000100", irom_read_en, irom_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL load_valid_c1: got %b want 0", instr_valid); end
        cyc(); #1;
        n_checks++; if (irom_read_en !== 1'b1 || irom_addr !== 32'h104) begin n_fail++; $display("FAIL load_issue1: got en=%b addr=%h want en=1 addr=00000104", irom_read_en, irom_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL load_valid_c2: got %b want 0", instr_valid); end
        cyc(); #1;
        n_checks++; if (irom_read_en !== 1'b1 || irom_addr !== 32'h108) begin n_fail++; $display("FAIL load_issue2: got en=%b addr=%h want en=1 addr=00000108", irom_read_en, irom_addr); end
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_out !== 32'h1E02_7413) begin n_fail++; $display("FAIL load_first_valid: got v=%b pc=%h instr=%h want v=1 pc=00000100 instr=1e027413", instr_valid, instr_pc, instr_out); end
        for (int i = 0; i < 8; i++) begin
            cyc(); #1;
            n_checks++; if (irom_read_en !== 1'b1) begin n_fail++; $display("FAIL steady_issue%0d: got %b want 1", i, irom_read_en); end
        end
        cyc(); #1;
        n_checks++; if (n_consumed - base != 9) begin n_fail++; $display("FAIL steady_throughput: got %0d want 9", n_consumed - base); end
    endtask

    task automatic test_stall();
        logic [31:0] frozen_instr, frozen_pc;
        cyc(); stall = 1'b1; #1;
        frozen_instr = instr_out; frozen_pc = instr_pc;
        n_checks++; if (irom_read_en !== 1'b0) begin n_fail++; $display("FAIL stall_throttle0: got %b want 0", irom_read_en); end
        for (int i = 1; i < 5; i++) begin
            cyc(); #1;
            n_checks++; if (instr_out !== frozen_instr || instr_pc !== frozen_pc || instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_frozen%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", i, instr_valid, instr_pc, instr_out, frozen_pc, frozen_instr); end
            n_checks++; if (irom_read_en !== 1'b0) begin n_fail++; $display("FAIL stall_throttle%0d: got %b want 0", i, irom_read_en); end
        end
        cyc(); stall = 1'b0; #1;
        n_checks++; if (irom_read_en !== 1'b1) begin n_fail++; $display("FAIL stall_release_issue: got %b want 1", irom_read_en); end
        for (int i = 0; i < 6; i++) cyc();
    endtask

    task automatic test_branch();
        cyc(); load_first_addr = 1'b1; first_addr = 32'h100; stall = 1'b1; sb_restart(32'h100, 8);
        cyc(); load_first_addr = 1'b0; stall = 1'b0;
        cyc(); cyc(); cyc(); #1;
        n_checks++; if (irom_read_en !== 1'b1 || irom_addr !== 32'h10C) begin n_fail++; $display("FAIL br_pre_issue: got en=%b addr=%h want en=1 addr=0000010c", irom_read_en, irom_addr); end
        cyc(); br_taken = 1'b1; br_target = 32'h200; stall = 1'b1; sb_restart(32'h200, 32); #1;
        n_checks++; if (irom_read_en !== 1'b0) begin n_fail++; $display("FAIL br_cycle_read_en: got %b want 0", irom_read_en); end
        n_checks++; if (instr_pc !== 32'h108) begin n_fail++; $display("FAIL br_stalled_head: got %h want 00000108", instr_pc); end
        cyc(); br_taken = 1'b0; stall = 1'b0; #1;
        n_checks++; if (instr_valid !== 1'b0 || irom_read_en !== 1'b1 || irom_addr !== 32'h200) begin n_fail++; $display("FAIL br_issue0: got v=%b en=%b addr=%h want v=0 en=1 addr=00000200", instr_valid, irom_read_en, irom_addr); end
        cyc(); #1;
        n_checks++; if (instr_valid !== 1'b0 || irom_addr !== 32'h204) begin n_fail++; $display("FAIL br_issue1: got v=%b addr=%h want v=0 addr=00000204", instr_valid, irom_addr); end
        cyc(); #1;
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin n_fail++; $display("FAIL br_first_valid: got v=%b pc=%h want v=1 pc=00000200", instr_valid, instr_pc); end
        for (int i = 0; i < 3; i++) cyc();
    endtask

    task automatic test_misalign();
        cyc(); br_taken = 1'b1; br_target = 32'h202; stall = 1'b1; sb_restart(32'h200, 16); #1;
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_br_early: got %b want 0", misalign_err); end
        cyc(); br_taken = 1'b0; stall = 1'b0; #1;
        n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_br_pulse: got %b want 1", misalign_err); end
        n_checks++; if (irom_read_en !== 1'b1 || irom_addr !== 32'h200) begin n_fail++; $display("FAIL mis_br_aligned: got en=%b addr=%h want en=1 addr=00000200", irom_read_en, irom_addr); end
        cyc(); #1;
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_br_width: got %b want 0", misalign_err); end
        cyc(); cyc();
        stall = 1'b1; load_first_addr = 1'b1; first_addr = 32'h301; sb_restart(32'h300, 16);
        cyc(); load_first_addr = 1'b0; stall = 1'b0; #1;
        n_checks++; if (misalign_err !== 1'b1 || irom_addr !== 32'h300) begin n_fail++; $display("FAIL mis_load: got err=%b addr=%h want err=1 addr=00000300", misalign_err, irom_addr); end
        for (int i = 0; i < 4; i++) cyc();
    endtask

    task automatic test_wrap();
        cyc(); load_first_addr = 1'b1; first_addr = 32'hFFFF_FFFC; stall = 1'b1; sb_restart(32'hFFFF_FFFC, 16);
        cyc(); load_first_addr = 1'b0; stall = 1'b0; #1;
        n_checks++; if (irom_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got %h want fffffffc", irom_addr); end
        cyc(); #1;
        n_checks++; if (irom_read_en !== 1'b1 || irom_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got en=%b addr=%h want en=1 addr=00000000", irom_read_en, irom_addr); end
        cyc(); #1;
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first: got v=%b pc=%h want v=1 pc=fffffffc", instr_valid, instr_pc); end
        for (int i = 0; i < 3; i++) cyc();
    endtask

    task automatic test_setup();
        cyc(); setup = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            n_checks++; if (irom_read_en !== 1'b0 || instr_out !== 32'h13 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL setup_hold%0d: got en=%b instr=%h v=%b want en=0 instr=00000013 v=0", i, irom_read_en, instr_out, instr_valid); end
        end
    endtask

    task automatic test_async_reset();
        cyc(); setup = 1'b0; load_first_addr = 1'b1; first_addr = 32'h100; sb_restart(32'h100, 16);
        cyc(); load_first_addr = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid: got %b want 1", instr_valid); end
        #2;
        sb_en = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (irom_read_en !== 1'b0 || irom_addr !== 32'h0) begin n_fail++; $display("FAIL areset_fetch: got en=%b addr=%h want en=0 addr=00000000", irom_read_en, irom_addr); end
        n_checks++; if (instr_out !== 32'h13 || instr_pc !== 32'h0 || instr_valid !== 1'b0 || misalign_err !== 1'b0) begin n_fail++; $display("FAIL areset_out: got instr=%h pc=%h v=%b err=%b want instr=00000013 pc=00000000 v=0 err=0", instr_out, instr_pc, instr_valid, misalign_err); end
        setup = 1'b1;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc(); #1;
        n_checks++; if (irom_read_en !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL areset_after: got en=%b v=%b want en=0 v=0", irom_read_en, instr_valid); end
    endtask

    initial begin
        test_reset();
        test_load_stream();
        test_stall();
        test_branch();
        test_misalign();
        test_wrap();
        test_setup();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
